// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for a shared-memory multi-cycle MIPS datapath.
// Sequences each instruction over 3-5 states, with optional memory wait states.
module mips_multicycle_ctrl #(
  parameter int unsigned OP_W         = 6,
  parameter bit          MEM_WAIT_EN  = 1'b0,
  parameter bit          ILLEGAL_MODE = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            extd,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_src,
  output logic            illegal_op,
  output logic [3:0]      state
);

  localparam logic [OP_W-1:0] OpRtype = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OpJ     = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OpBeq   = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OpAddi  = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OpLw    = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OpSw    = OP_W'(6'h2B);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  state_e state_q, state_d;
  logic   mem_done;
  logic   op_known;
  logic   pc_write;
  logic   branch;

  // Without wait states every memory access completes in one cycle.
  assign mem_done = !MEM_WAIT_EN || mem_ready;
  assign op_known = (opcode == OpRtype) || (opcode == OpJ) || (opcode == OpBeq) ||
                    (opcode == OpAddi) || (opcode == OpLw) || (opcode == OpSw);
  assign state    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = mem_done ? StDecode : StFetch;
      StDecode: begin
        if (opcode == OpRtype)                        state_d = StExec;
        else if (opcode == OpAddi)                    state_d = StAddiEx;
        else if (opcode == OpLw || opcode == OpSw)    state_d = StMemAdr;
        else if (opcode == OpBeq)                     state_d = StBranch;
        else if (opcode == OpJ)                       state_d = StJump;
        else                                          state_d = ILLEGAL_MODE ? StFetch : StExec;
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = mem_done ? StMemWb : StMemRd;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = mem_done ? StFetch : StMemWr;
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    extd       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    illegal_op = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC must not advance until the fetch data is actually valid.
        ir_write  = mem_done;
        pc_write  = mem_done;
      end
      StDecode: begin
        alu_src_b  = 2'b11;
        extd       = 1'b1;
        illegal_op = ILLEGAL_MODE && !op_known;
      end
      StMemAdr, StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        extd      = 1'b1;
      end
      StMemRd: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StAluWb: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      StAddiWb: reg_write = 1'b1;
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      StJump: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    pc_en = pc_write | (branch & zero);
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: instance a uses default parameters,
// instance b has memory wait states and illegal-opcode abort enabled.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode_a, opcode_b;
  logic zero_a, zero_b, mem_ready_a, mem_ready_b;

  logic a_pc_en, a_iord, a_mem_read, a_mem_write, a_ir_write, a_reg_dst, a_mem_to_reg;
  logic a_reg_write, a_extd, a_alu_src_a, a_illegal_op;
  logic [1:0] a_alu_src_b, a_alu_op, a_pc_src;
  logic [3:0] a_state;
  logic b_pc_en, b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_dst, b_mem_to_reg;
  logic b_reg_write, b_extd, b_alu_src_a, b_illegal_op;
  logic [1:0] b_alu_src_b, b_alu_op, b_pc_src;
  logic [3:0] b_state;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.OP_W(6), .MEM_WAIT_EN(1'b0), .ILLEGAL_MODE(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode_a), .zero(zero_a), .mem_ready(mem_ready_a),
    .pc_en(a_pc_en), .iord(a_iord), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .ir_write(a_ir_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
    .reg_write(a_reg_write), .extd(a_extd), .alu_src_a(a_alu_src_a),
    .alu_src_b(a_alu_src_b), .alu_op(a_alu_op), .pc_src(a_pc_src),
    .illegal_op(a_illegal_op), .state(a_state)
  );

  mips_multicycle_ctrl #(.OP_W(6), .MEM_WAIT_EN(1'b1), .ILLEGAL_MODE(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode_b), .zero(zero_b), .mem_ready(mem_ready_b),
    .pc_en(b_pc_en), .iord(b_iord), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .ir_write(b_ir_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
    .reg_write(b_reg_write), .extd(b_extd), .alu_src_a(b_alu_src_a),
    .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .pc_src(b_pc_src),
    .illegal_op(b_illegal_op), .state(b_state)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    opcode_a    = 6'h23;
    opcode_b    = 6'h23;
    zero_a      = 1'b0;
    zero_b      = 1'b0;
    mem_ready_a = 1'b0;
    mem_ready_b = 1'b1;

    // Reset and first fetch
    @(negedge clk); #1;
    chk("rst_state_a", a_state, 4'd0);
    chk("rst_state_b", b_state, 4'd0);
    rst_n = 1'b1;
    #1;
    chk("fetch_mem_read", {3'b0, a_mem_read}, 4'd1);
    chk("fetch_ir_write", {3'b0, a_ir_write}, 4'd1);
    chk("fetch_pc_en", {3'b0, a_pc_en}, 4'd1);
    chk("fetch_alu_src_b", {2'b0, a_alu_src_b}, 4'd1);
    chk("fetch_iord", {3'b0, a_iord}, 4'd0);

    // lw on a: 0,1,2,3,4,0 with mem_ready ignored
    tick(); chk("lw_s1", a_state, 4'd1);
    chk("dec_alu_src_b", {2'b0, a_alu_src_b}, 4'd3);
    chk("dec_extd", {3'b0, a_extd}, 4'd1);
    tick(); chk("lw_s2", a_state, 4'd2);
    chk("madr_srcb", {2'b0, a_alu_src_b}, 4'd2);
    chk("madr_srca", {3'b0, a_alu_src_a}, 4'd1);
    tick(); chk("lw_s3", a_state, 4'd3);
    chk("mrd_iord_read", {2'b0, a_iord, a_mem_read}, 4'd3);
    chk("mrd_reg_write", {3'b0, a_reg_write}, 4'd0);
    tick(); chk("lw_s4", a_state, 4'd4);
    chk("mwb_wr_m2r_dst", {1'b0, a_reg_write, a_mem_to_reg, a_reg_dst}, 4'b0110);
    tick(); chk("lw_s0", a_state, 4'd0);
    chk("lw_done_regwr", {3'b0, a_reg_write}, 4'd0);

    // beq on a: 0,1,8,0 and pc_en follows zero
    opcode_a = 6'h04;
    tick(); chk("beq_s1", a_state, 4'd1);
    tick(); chk("beq_s8", a_state, 4'd8);
    zero_a = 1'b1; #1;
    chk("beq_pc_en_z1", {3'b0, a_pc_en}, 4'd1);
    chk("beq_pc_src", {2'b0, a_pc_src}, 4'd1);
    chk("beq_alu_op", {2'b0, a_alu_op}, 4'd1);
    zero_a = 1'b0; #1;
    chk("beq_pc_en_z0", {3'b0, a_pc_en}, 4'd0);
    tick(); chk("beq_s0", a_state, 4'd0);

    // R-type on a: 0,1,6,7,0
    opcode_a = 6'h00;
    tick(); chk("r_s1", a_state, 4'd1);
    tick(); chk("r_s6", a_state, 4'd6);
    chk("exec_alu_op", {2'b0, a_alu_op}, 4'd2);
    tick(); chk("r_s7", a_state, 4'd7);
    chk("aluwb_wr_dst", {2'b0, a_reg_write, a_reg_dst}, 4'd3);
    tick(); chk("r_s0", a_state, 4'd0);

    // Unknown opcode with legacy handling runs as R-type
    opcode_a = 6'h3F;
    tick(); chk("ill0_s1", a_state, 4'd1);
    chk("ill0_flag", {3'b0, a_illegal_op}, 4'd0);
    tick(); chk("ill0_s6", a_state, 4'd6);
    tick(); chk("ill0_s7", a_state, 4'd7);
    tick(); chk("ill0_s0", a_state, 4'd0);

    // j on a: 0,1,11,0
    opcode_a = 6'h02;
    tick(); chk("j_s1", a_state, 4'd1);
    tick(); chk("j_s11", a_state, 4'd11);
    chk("j_pc_src", {2'b0, a_pc_src}, 4'd2);
    chk("j_pc_en", {3'b0, a_pc_en}, 4'd1);
    tick(); chk("j_s0", a_state, 4'd0);

    // Re-align both instances for the wait-state instance
    rst_n = 1'b0; mem_ready_b = 1'b0; opcode_b = 6'h2B; #1;
    chk("rst2_state_b", b_state, 4'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("wfetch_ir_write", {3'b0, b_ir_write}, 4'd0);
    chk("wfetch_pc_en", {3'b0, b_pc_en}, 4'd0);
    chk("wfetch_mem_read", {3'b0, b_mem_read}, 4'd1);
    tick(); chk("wfetch_hold", b_state, 4'd0);
    mem_ready_b = 1'b1; #1;
    chk("wfetch_rdy_ir", {3'b0, b_ir_write}, 4'd1);
    chk("wfetch_rdy_pc", {3'b0, b_pc_en}, 4'd1);
    tick(); chk("sw_s1", b_state, 4'd1);
    tick(); chk("sw_s2", b_state, 4'd2);
    mem_ready_b = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("sw_wait_state", b_state, 4'd5);
      chk("sw_wait_mem_write", {3'b0, b_mem_write}, 4'd1);
      chk("sw_wait_reg_write", {3'b0, b_reg_write}, 4'd0);
      tick();
    end
    chk("sw_last_state", b_state, 4'd5);
    mem_ready_b = 1'b1; #1;
    chk("sw_last_mem_write", {3'b0, b_mem_write}, 4'd1);
    tick(); chk("sw_s0", b_state, 4'd0);
    chk("sw_done_mem_write", {3'b0, b_mem_write}, 4'd0);

    // Illegal opcode abort on b: 0,1,0 with a single-cycle pulse
    opcode_b = 6'h3F;
    chk("ill1_pre", {3'b0, b_illegal_op}, 4'd0);
    tick(); chk("ill1_s1", b_state, 4'd1);
    chk("ill1_pulse", {3'b0, b_illegal_op}, 4'd1);
    tick(); chk("ill1_s0", b_state, 4'd0);
    chk("ill1_post", {3'b0, b_illegal_op}, 4'd0);

    // addi on b: 0,1,9,10,0
    opcode_b = 6'h08;
    tick(); chk("addi_s1", b_state, 4'd1);
    chk("addi_no_ill", {3'b0, b_illegal_op}, 4'd0);
    tick(); chk("addi_s9", b_state, 4'd9);
    chk("addiex_srcb_extd", {1'b0, b_alu_src_b, b_extd}, 4'b0101);
    tick(); chk("addi_s10", b_state, 4'd10);
    chk("addiwb_wr_dst", {2'b0, b_reg_write, b_reg_dst}, 4'd2);
    tick(); chk("addi_s0", b_state, 4'd0);

    // Reset asserted during MEMRD of lw on a
    rst_n = 1'b0; opcode_a = 6'h23; #1;
    @(negedge clk); rst_n = 1'b1;
    tick(); chk("abort_s1", a_state, 4'd1);
    tick(); chk("abort_s2", a_state, 4'd2);
    tick(); chk("abort_s3", a_state, 4'd3);
    rst_n = 1'b0; #1;
    chk("abort_async_state", a_state, 4'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_hold_reg_write", {3'b0, a_reg_write}, 4'd0);
      chk("abort_hold_state", a_state, 4'd0);
      tick();
    end
    rst_n = 1'b1; #1;
    chk("abort_rel_state", a_state, 4'd0);
    tick(); chk("abort_rel_s1", a_state, 4'd1);
    chk("abort_rel_reg_write", {3'b0, a_reg_write}, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
